// File: rtl/byte_data_memory_pkg.sv
// Shared encodings for the byte-addressable data memory: access sizes, FSM states
// and the lane helpers used by both the store path and the fault check.
package byte_data_memory_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int WORD_BYTES = 4;

    function automatic logic access_fault(input logic [1:0] size, input logic [1:0] offset);
        logic f;
        case (size)
            SIZE_BYTE: f = 1'b0;
            SIZE_HALF: f = offset[0];
            SIZE_WORD: f = (offset != 2'b00);
            default:   f = 1'b1;
        endcase
        return f;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << offset;
            SIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian lane extraction with sign/zero extension for loads; purely
// combinational so it can sit behind any word-wide read source.
module load_align
    import byte_data_memory_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[8*offset +: 8];
        half_lane = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SIZE_HALF: data = {{16{sign_ext & half_lane[15]}}, half_lane};
            SIZE_WORD: data = word;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable data memory with fixed wait states, a one-cycle ready pulse and
// misalignment faults. Stores commit and loads register on the edge entering RESP.
//
// state | meaning
// IDLE  | waiting for req; request fields are taken straight from the ports
// WAIT  | counting WAIT_STATES cycles on the latched request
// RESP  | ready=1 for one cycle; fault/ReadData valid
module byte_data_memory
    import byte_data_memory_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 256,
    parameter int WAIT_STATES  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  MemWrite,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ready,
    output logic                  fault
);

    localparam int AW = $clog2(MEMORY_DEPTH);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("byte_data_memory: DATA_WIDTH must be 32");
    end
    if (MEMORY_DEPTH < 2 || (MEMORY_DEPTH & (MEMORY_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("byte_data_memory: MEMORY_DEPTH must be a power of two >= 2");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("byte_data_memory: WAIT_STATES must be 0..15");
    end

    state_e state, state_next;
    logic [3:0] wait_cnt;

    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_sx;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        cur_we;
    logic [1:0]  cur_size;
    logic        cur_sx;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_fault;
    logic        enter_resp;
    logic        write_en;

    logic [AW-1:0] word_idx;
    logic [3:0]    be;
    logic [31:0]   lane_wdata;
    logic [31:0]   rd_word;
    logic [31:0]   load_data;
    logic          fault_q;

    logic [31:0] mem [MEMORY_DEPTH];

    // In IDLE the accepting edge must act on the port values; afterwards only latched ones.
    always_comb begin
        if (state == IDLE) begin
            cur_we    = MemWrite;
            cur_size  = size;
            cur_sx    = sign_ext;
            cur_addr  = Address;
            cur_wdata = WriteData;
        end else begin
            cur_we    = lat_we;
            cur_size  = lat_size;
            cur_sx    = lat_sx;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
        end
    end

    assign cur_fault = access_fault(cur_size, cur_addr[1:0]);
    assign word_idx  = cur_addr[AW+1:2];
    assign be        = byte_enables(cur_size, cur_addr[1:0]);

    logic unused_addr_bits;
    assign unused_addr_bits = ^cur_addr[31:AW+2];

    always_comb begin
        state_next = state;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (cur_fault || WAIT_STATES == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign write_en = enter_resp && cur_we && !cur_fault && !reset;

    always_comb begin
        case (cur_size)
            SIZE_BYTE: lane_wdata = {4{cur_wdata[7:0]}};
            SIZE_HALF: lane_wdata = {2{cur_wdata[15:0]}};
            default:   lane_wdata = cur_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && req && !cur_fault && WAIT_STATES != 0)
                wait_cnt <= 4'(WAIT_STATES - 1);
            else if (state == WAIT && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_size  <= SIZE_BYTE;
            lat_sx    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && req) begin
            lat_we    <= MemWrite;
            lat_size  <= size;
            lat_sx    <= sign_ext;
            lat_addr  <= Address;
            lat_wdata <= WriteData;
        end
    end

    // Not reset: contents survive reset.
    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be[i])
                    mem[word_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
            end
        end
    end

    assign rd_word = mem[word_idx];

    load_align u_load_align (
        .word     (rd_word),
        .offset   (cur_addr[1:0]),
        .size     (cur_size),
        .sign_ext (cur_sx),
        .data     (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ReadData <= '0;
            fault_q  <= 1'b0;
        end else if (enter_resp) begin
            fault_q <= cur_fault;
            if (cur_fault)
                ReadData <= '0;
            else if (!cur_we)
                ReadData <= load_data;
        end
    end

    assign ready = (state == RESP);
    assign fault = (state == RESP) && fault_q;

endmodule

// File: tb/tb_byte_data_memory.sv
// Directed bench: one instance with WAIT_STATES=1, one with WAIT_STATES=3;
// hand-computed expectations for latency, fault, ReadData and memory contents.
module tb_byte_data_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_v [2];
    logic        req_v   [2];
    logic        we_v    [2];
    logic        sx_v    [2];
    logic [1:0]  size_v  [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [31:0] rdata_v [2];
    logic        ready_v [2];
    logic        fault_v [2];

    int n_cmp = 0;
    int n_err = 0;

    byte_data_memory #(.DATA_WIDTH(32), .MEMORY_DEPTH(256), .WAIT_STATES(1)) dut_a (
        .clk(clk), .reset(reset_v[0]), .req(req_v[0]), .MemWrite(we_v[0]), .size(size_v[0]),
        .sign_ext(sx_v[0]), .Address(addr_v[0]), .WriteData(wdata_v[0]),
        .ReadData(rdata_v[0]), .ready(ready_v[0]), .fault(fault_v[0])
    );

    byte_data_memory #(.DATA_WIDTH(32), .MEMORY_DEPTH(256), .WAIT_STATES(3)) dut_b (
        .clk(clk), .reset(reset_v[1]), .req(req_v[1]), .MemWrite(we_v[1]), .size(size_v[1]),
        .sign_ext(sx_v[1]), .Address(addr_v[1]), .WriteData(wdata_v[1]),
        .ReadData(rdata_v[1]), .ready(ready_v[1]), .fault(fault_v[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request; latency counted in negedges after the accepting posedge.
    task automatic access(input int d, input string tag, input logic we, input logic [1:0] sz,
                          input logic sx, input logic [31:0] addr, input logic [31:0] wd,
                          input bit hold, input bit chk_rd, input logic [31:0] exp_rd,
                          input bit exp_flt);
        int lat;
        int exp_lat;
        bit seen;
        exp_lat = exp_flt ? 1 : ((d == 0) ? 2 : 4);
        @(negedge clk);
        req_v[d] = 1'b1; we_v[d] = we; size_v[d] = sz; sx_v[d] = sx;
        addr_v[d] = addr; wdata_v[d] = wd;
        @(posedge clk);
        #1;
        if (!hold) req_v[d] = 1'b0;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (ready_v[d]) seen = 1'b1;
            else check({tag, " fault while not ready"}, 32'(fault_v[d]), 32'd0);
        end
        req_v[d] = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " fault"}, 32'(fault_v[d]), 32'(exp_flt));
        if (chk_rd) check({tag, " rdata"}, rdata_v[d], exp_rd);
    endtask

    task automatic quiet(input int d, input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, " no ready"}, 32'(ready_v[d]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset_v[d] = 1'b1; req_v[d] = 1'b0; we_v[d] = 1'b0; sx_v[d] = 1'b0;
            size_v[d] = 2'b00; addr_v[d] = '0; wdata_v[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset ready", 32'(ready_v[d]), 32'd0);
            check("reset fault", 32'(fault_v[d]), 32'd0);
            check("reset rdata", rdata_v[d], 32'd0);
        end
        reset_v[0] = 1'b0;
        reset_v[1] = 1'b0;

        // Scenario 1: word store / load
        access(0, "s1 st", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        access(0, "s1 ld", 0, 2'b10, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, 0);

        // Scenario 2: byte store over a cleared word
        access(0, "s2 clr", 1, 2'b10, 0, 32'h10, 32'h00000000, 0, 0, 0, 0);
        access(0, "s2 st", 1, 2'b00, 0, 32'h11, 32'hAAAA557F, 0, 0, 0, 0);
        access(0, "s2 ldb", 0, 2'b00, 0, 32'h11, 32'h0, 0, 1, 32'h0000007F, 0);
        access(0, "s2 ldbs", 0, 2'b00, 1, 32'h11, 32'h0, 0, 1, 32'h0000007F, 0);
        access(0, "s2 ldw", 0, 2'b10, 1, 32'h10, 32'h0, 0, 1, 32'h00007F00, 0);

        // Scenario 3: upper half store, signed/unsigned half and byte loads
        access(0, "s3 st", 1, 2'b01, 0, 32'h12, 32'h12348001, 0, 0, 0, 0);
        access(0, "s3 ldhs", 0, 2'b01, 1, 32'h12, 32'h0, 0, 1, 32'hFFFF8001, 0);
        access(0, "s3 ldhu", 0, 2'b01, 0, 32'h12, 32'h0, 0, 1, 32'h00008001, 0);
        access(0, "s3 ldbs", 0, 2'b00, 1, 32'h13, 32'h0, 0, 1, 32'hFFFFFF80, 0);
        access(0, "s3 ldbu", 0, 2'b00, 0, 32'h12, 32'h0, 0, 1, 32'h00000001, 0);
        access(0, "s3 ldw", 0, 2'b10, 0, 32'h10, 32'h0, 0, 1, 32'h80017F00, 0);

        // Scenario 4: faults give ready+fault after one cycle, ReadData=0, no write
        access(0, "s4 wst", 1, 2'b10, 0, 32'h13, 32'hFFFFFFFF, 0, 1, 32'h0, 1);
        check("s4 pulse ready", 32'(ready_v[0]), 32'd1);
        @(negedge clk);
        check("s4 after ready", 32'(ready_v[0]), 32'd0);
        check("s4 after fault", 32'(fault_v[0]), 32'd0);
        access(0, "s4 ld pre", 0, 2'b10, 0, 32'h10, 32'h0, 0, 1, 32'h80017F00, 0);
        access(0, "s4 rsvd", 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 0, 1, 32'h0, 1);
        access(0, "s4 hst", 1, 2'b01, 0, 32'h11, 32'hFFFFFFFF, 0, 1, 32'h0, 1);
        access(0, "s4 ldw", 0, 2'b10, 0, 32'h10, 32'h0, 0, 1, 32'h80017F00, 0);

        // Scenario 6: address wrap and req held through WAIT
        access(0, "s6 st", 1, 2'b10, 0, 32'h400, 32'h55AA55AA, 1, 0, 0, 0);
        quiet(0, "s6 single", 3);
        access(0, "s6 ld0", 0, 2'b10, 0, 32'h0, 32'h0, 0, 1, 32'h55AA55AA, 0);
        access(0, "s6 ldwrap", 0, 2'b10, 0, 32'h410, 32'h0, 0, 1, 32'h80017F00, 0);
        repeat (2) @(negedge clk);
        check("s6 rdata hold", rdata_v[0], 32'h80017F00);

        // Scenario 5: WAIT_STATES=3, reset during the 2nd wait cycle drops the store
        access(1, "s5 init", 1, 2'b10, 0, 32'h20, 32'h11223344, 0, 0, 0, 0);
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b1; size_v[1] = 2'b10; sx_v[1] = 1'b0;
        addr_v[1] = 32'h20; wdata_v[1] = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_v[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_v[1] = 1'b1;
        @(negedge clk);
        reset_v[1] = 1'b0;
        check("s5 rst fault", 32'(fault_v[1]), 32'd0);
        check("s5 rst rdata", rdata_v[1], 32'd0);
        quiet(1, "s5 dropped", 5);
        access(1, "s5 ld", 0, 2'b10, 0, 32'h20, 32'h0, 0, 1, 32'h11223344, 0);
        access(1, "s5 ldb", 0, 2'b00, 1, 32'h21, 32'h0, 0, 1, 32'h00000033, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
